// File: rtl/logic_operand_seq.sv
// ============================================================================
// Module   : logic_operand_seq
// Purpose  : Sweeps a programmable run of packed {a,b,c} operand vectors over
//            a valid/ready handshake, with issued/last/done progress status.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module logic_operand_seq #(
   parameter int BW     = 3,
   parameter int STRIDE = 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic [2*BW:0]     first,
   input  logic [2*BW+1:0]   count,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              a,
   output logic [BW-1:0]     b,
   output logic [BW-1:0]     c,
   output logic              out_last,
   output logic              busy,
   output logic              done,
   output logic [2*BW+1:0]   issued
);

   localparam int N = 2*BW + 1;

   localparam logic [N-1:0] STEP    = N'(STRIDE);
   localparam logic [N:0]   ONE_CNT = (N+1)'(1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]   state_q,     state_d;
   logic [N-1:0] vec_q,       vec_d;
   logic [N:0]   remaining_q, remaining_d;
   logic [N:0]   issued_q,    issued_d;

   logic xfer;
   logic last_vec;

   assign last_vec = (remaining_q == ONE_CNT);
   assign xfer     = (state_q == S_RUN) && out_ready;

   // State register
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= S_IDLE;
         vec_q       <= '0;
         remaining_q <= '0;
         issued_q    <= '0;
      end else begin
         state_q     <= state_d;
         vec_q       <= vec_d;
         remaining_q <= remaining_d;
         issued_q    <= issued_d;
      end
   end

   // Next-state and datapath update
   always_comb begin
      state_d     = state_q;
      vec_d       = vec_q;
      remaining_d = remaining_q;
      issued_d    = issued_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               vec_d       = first;
               remaining_d = count;
               issued_d    = '0;
               state_d     = (count == '0) ? S_DONE : S_RUN;
            end
         end
         S_RUN: begin
            if (xfer) begin
               // Vector wraps modulo 2^N without any flag.
               vec_d       = vec_q + STEP;
               remaining_d = remaining_q - ONE_CNT;
               issued_d    = issued_q + ONE_CNT;
               if (last_vec) begin
                  state_d = S_DONE;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Outputs
   always_comb begin
      out_valid = (state_q == S_RUN);
      out_last  = (state_q == S_RUN) && last_vec;
      busy      = (state_q != S_IDLE);
      done      = (state_q == S_DONE);
   end

   assign a      = vec_q[N-1];
   assign b      = vec_q[2*BW-1:BW];
   assign c      = vec_q[BW-1:0];
   assign issued = issued_q;

endmodule

`default_nettype wire
